// File: rtl/bus_endpoint_if.sv
// rtl/bus_endpoint_if.sv - host/arbiter bus bundle for bus_endpoint
interface bus_endpoint_if #(
    parameter int pckg_sz = 32
);
    logic               tx_valid;
    logic [pckg_sz-1:0] tx_data;
    logic               tx_ready;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               rx_valid;
    logic [pckg_sz-1:0] rx_data;
    logic               rx_ready;
    logic [7:0]         drop_cnt;
    logic               err_pop;

    modport slave (
        input  tx_valid, tx_data, pop, push, D_push, rx_ready,
        output tx_ready, pndng, D_pop, rx_valid, rx_data, drop_cnt, err_pop
    );

    modport master (
        output tx_valid, tx_data, pop, push, D_push, rx_ready,
        input  tx_ready, pndng, D_pop, rx_valid, rx_data, drop_cnt, err_pop
    );
endinterface

// File: rtl/bus_endpoint.sv
// rtl/bus_endpoint.sv - bus endpoint with TX/RX show-ahead FIFOs and address filter

// Show-ahead FIFO; callers gate wr_en/rd_en with full/empty themselves.
module bus_endpoint_fifo #(
    parameter int width = 32,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] depth_c = (aw + 1)'(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic [aw:0]      count;

    assign full    = (count == depth_c);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are meaningless until the count says otherwise.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (aw + 1)'(1);
                2'b01:   count <= count - (aw + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module bus_endpoint #(
    parameter int          pckg_sz   = 32,
    parameter int          depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    bus_endpoint_if.slave bus
);
    logic       tx_full;
    logic       tx_empty;
    logic       tx_wr;
    logic       tx_rd;
    logic       rx_full;
    logic       rx_empty;
    logic       rx_wr;
    logic       rx_rd;
    logic [7:0] dest;
    logic       addr_hit;
    logic       rx_drop;

    // Full/empty come from registered counts, so a same-cycle read never
    // makes room for a write and a same-cycle write never feeds a read.
    assign tx_wr = bus.tx_valid && !tx_full;
    assign tx_rd = bus.pop && !tx_empty;

    assign dest     = bus.D_push[pckg_sz-1 -: 8];
    assign addr_hit = bus.push && ((dest == id) || (dest == broadcast));
    assign rx_wr    = addr_hit && !rx_full;
    assign rx_drop  = addr_hit && rx_full;
    assign rx_rd    = bus.rx_ready && !rx_empty;

    assign bus.tx_ready = !tx_full;
    assign bus.pndng    = !tx_empty;
    assign bus.rx_valid = !rx_empty;

    bus_endpoint_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data (bus.tx_data),
        .rd_en   (tx_rd),
        .rd_data (bus.D_pop),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    bus_endpoint_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_wr),
        .wr_data (bus.D_push),
        .rd_en   (rx_rd),
        .rd_data (bus.rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    // Sticky error: arbiter popped while nothing was pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.err_pop <= 1'b0;
        end else if (bus.pop && tx_empty) begin
            bus.err_pop <= 1'b1;
        end
    end

    // Count packets addressed to us that found the RX FIFO full; saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.drop_cnt <= 8'd0;
        end else if (rx_drop && (bus.drop_cnt != 8'hFF)) begin
            bus.drop_cnt <= bus.drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_bus_endpoint.sv
// tb/tb_bus_endpoint.sv - directed self-checking bench for bus_endpoint
module tb_bus_endpoint;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bus_endpoint_if #(.pckg_sz(32)) bif ();

    bus_endpoint #(
        .pckg_sz   (32),
        .depth     (8),
        .id        (8'h03),
        .broadcast (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.tx_valid = 1'b0;
        bif.tx_data  = '0;
        bif.pop      = 1'b0;
        bif.push     = 1'b0;
        bif.D_push   = '0;
        bif.rx_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        chk("rst_tx_ready", 32'(bif.tx_ready), 32'd1);
        chk("rst_pndng",    32'(bif.pndng),    32'd0);
        chk("rst_rx_valid", 32'(bif.rx_valid), 32'd0);
        chk("rst_drop_cnt", 32'(bif.drop_cnt), 32'd0);
        chk("rst_err_pop",  32'(bif.err_pop),  32'd0);

        // Three TX packets popped in order
        for (int i = 1; i <= 3; i++) begin
            bif.tx_valid = 1'b1;
            bif.tx_data  = 32'h0100_0000 + 32'(i);
            cycle();
        end
        bif.tx_valid = 1'b0;
        chk("tx3_pndng", 32'(bif.pndng), 32'd1);
        chk("tx3_head1", bif.D_pop, 32'h0100_0001);
        bif.pop = 1'b1;
        cycle();
        chk("tx3_head2", bif.D_pop, 32'h0100_0002);
        cycle();
        chk("tx3_head3", bif.D_pop, 32'h0100_0003);
        cycle();
        bif.pop = 1'b0;
        chk("tx3_empty", 32'(bif.pndng), 32'd0);
        chk("tx3_no_err", 32'(bif.err_pop), 32'd0);

        // TX fill, overflow attempt, single pop frees a slot
        for (int i = 0; i < 8; i++) begin
            bif.tx_valid = 1'b1;
            bif.tx_data  = 32'h0000_00A0 + 32'(i);
            cycle();
        end
        chk("txfull_ready", 32'(bif.tx_ready), 32'd0);
        bif.tx_data = 32'h0000_DEAD;
        cycle();
        bif.tx_valid = 1'b0;
        chk("txfull_ready2", 32'(bif.tx_ready), 32'd0);
        chk("txfull_head", bif.D_pop, 32'h0000_00A0);
        bif.pop = 1'b1;
        cycle();
        bif.pop = 1'b0;
        chk("txfull_ready_after_pop", 32'(bif.tx_ready), 32'd1);
        for (int i = 1; i < 8; i++) begin
            chk("txfull_drain", bif.D_pop, 32'h0000_00A0 + 32'(i));
            bif.pop = 1'b1;
            cycle();
        end
        bif.pop = 1'b0;
        chk("txfull_9th_not_stored", 32'(bif.pndng), 32'd0);

        // Simultaneous write and valid pop keeps order and count
        bif.tx_valid = 1'b1;
        bif.tx_data  = 32'h0000_0011;
        cycle();
        bif.tx_data  = 32'h0000_0022;
        bif.pop      = 1'b1;
        cycle();
        bif.tx_valid = 1'b0;
        bif.pop      = 1'b0;
        chk("wrpop_pndng", 32'(bif.pndng), 32'd1);
        chk("wrpop_head",  bif.D_pop, 32'h0000_0022);
        chk("wrpop_no_err", 32'(bif.err_pop), 32'd0);
        bif.pop = 1'b1;
        cycle();
        bif.pop = 1'b0;
        chk("wrpop_drained", 32'(bif.pndng), 32'd0);

        // Pop on empty sets sticky error
        bif.pop = 1'b1;
        cycle();
        bif.pop = 1'b0;
        chk("errpop_set",   32'(bif.err_pop),  32'd1);
        chk("errpop_pndng", 32'(bif.pndng),    32'd0);
        chk("errpop_ready", 32'(bif.tx_ready), 32'd1);
        cycle();
        chk("errpop_sticky", 32'(bif.err_pop), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("errpop_cleared", 32'(bif.err_pop), 32'd0);

        // Write into empty with simultaneous pop: pop ignored, error flagged
        bif.tx_valid = 1'b1;
        bif.tx_data  = 32'h0000_0033;
        bif.pop      = 1'b1;
        cycle();
        bif.tx_valid = 1'b0;
        bif.pop      = 1'b0;
        chk("wrempty_pndng", 32'(bif.pndng), 32'd1);
        chk("wrempty_head",  bif.D_pop, 32'h0000_0033);
        chk("wrempty_err",   32'(bif.err_pop), 32'd1);
        bif.pop = 1'b1;
        cycle();
        bif.pop = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;

        // Address filter: own id, foreign id, broadcast
        bif.push   = 1'b1;
        bif.D_push = 32'h0300_00AA;
        cycle();
        chk("rx_latency_valid", 32'(bif.rx_valid), 32'd1);
        chk("rx_first", bif.rx_data, 32'h0300_00AA);
        bif.D_push = 32'h0500_00BB;
        cycle();
        bif.D_push = 32'hFF00_00CC;
        cycle();
        bif.push     = 1'b0;
        bif.rx_ready = 1'b1;
        chk("rx_head_aa", bif.rx_data, 32'h0300_00AA);
        cycle();
        chk("rx_head_cc", bif.rx_data, 32'hFF00_00CC);
        chk("rx_still_valid", 32'(bif.rx_valid), 32'd1);
        cycle();
        bif.rx_ready = 1'b0;
        chk("rx_bb_discarded", 32'(bif.rx_valid), 32'd0);
        chk("rx_no_drop", 32'(bif.drop_cnt), 32'd0);

        // RX overflow: 10 pushes, 8 stored, 2 dropped
        for (int i = 0; i < 10; i++) begin
            bif.push   = 1'b1;
            bif.D_push = 32'h0300_0000 + 32'(i);
            cycle();
        end
        chk("rxfull_drop2", 32'(bif.drop_cnt), 32'd2);
        chk("rxfull_head",  bif.rx_data, 32'h0300_0000);
        // Read while full does not make room for a same-cycle push
        bif.D_push   = 32'h0300_0100;
        bif.rx_ready = 1'b1;
        cycle();
        bif.push = 1'b0;
        chk("rxfull_rdpush_drop", 32'(bif.drop_cnt), 32'd3);
        for (int i = 1; i < 8; i++) begin
            chk("rxfull_drain", bif.rx_data, 32'h0300_0000 + 32'(i));
            cycle();
        end
        chk("rxfull_drained", 32'(bif.rx_valid), 32'd0);
        // rx_ready with nothing held has no effect
        cycle();
        bif.rx_ready = 1'b0;
        bif.push     = 1'b1;
        bif.D_push   = 32'h0300_0055;
        cycle();
        bif.push = 1'b0;
        chk("rx_idle_ready_valid", 32'(bif.rx_valid), 32'd1);
        chk("rx_idle_ready_data",  bif.rx_data, 32'h0300_0055);

        // drop_cnt saturation
        bif.push   = 1'b1;
        bif.D_push = 32'h0300_0077;
        for (int i = 0; i < 270; i++) begin
            cycle();
        end
        bif.push = 1'b0;
        chk("drop_saturate", 32'(bif.drop_cnt), 32'd255);

        // Reset mid-operation with loaded FIFOs and active inputs
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bif.tx_valid = 1'b1;
            bif.tx_data  = 32'h0900_0000 + 32'(i);
            bif.push     = 1'b1;
            bif.D_push   = 32'h0300_0200 + 32'(i);
            cycle();
        end
        chk("load_pndng", 32'(bif.pndng), 32'd1);
        chk("load_rx_valid", 32'(bif.rx_valid), 32'd1);
        bif.pop      = 1'b1;
        bif.rx_ready = 1'b1;
        reset        = 1'b1;
        cycle();
        reset = 1'b0;
        idle_inputs();
        chk("mid_rst_tx_ready", 32'(bif.tx_ready), 32'd1);
        chk("mid_rst_pndng",    32'(bif.pndng),    32'd0);
        chk("mid_rst_rx_valid", 32'(bif.rx_valid), 32'd0);
        chk("mid_rst_drop_cnt", 32'(bif.drop_cnt), 32'd0);
        chk("mid_rst_err_pop",  32'(bif.err_pop),  32'd0);
        cycle();
        chk("post_rst_pndng",    32'(bif.pndng),    32'd0);
        chk("post_rst_rx_valid", 32'(bif.rx_valid), 32'd0);
        bif.tx_valid = 1'b1;
        bif.tx_data  = 32'h0000_0ABC;
        cycle();
        bif.tx_valid = 1'b0;
        chk("post_rst_fresh_head", bif.D_pop, 32'h0000_0ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
